// File: rtl/mem_pkg.sv
// Shared types and constants for the 256-bit memory port requester.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 256;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_OUT  = 3'd3,
        WR_WAIT = 3'd4,
        WR_REQ  = 3'd5,
        DONE    = 3'd6
    } req_state_t;

endpackage

// File: rtl/mem_requester.sv
// Block-transfer initiator: turns one command into single-word memory requests,
// streaming read words out and pulling write words in over valid/ready.
module mem_requester
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LEN_W   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdRW,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [LEN_W-1:0]  cmdLen,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    input  logic              rdReady,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wrValid,
    output logic              wrReady,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRW,
    output logic              memEN,
    output logic [DATA_W-1:0] memWrite,
    input  logic [DATA_W-1:0] memBus
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    req_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_rdData, r_memWrite;
    logic              w_cmdHs, w_rdHs, w_wrHs, w_latDone, w_last;

    assign w_cmdHs   = cmdValid && (r_state == IDLE);
    assign w_rdHs    = rdReady && (r_state == RD_OUT);
    assign w_wrHs    = wrValid && (r_state == WR_WAIT);
    assign w_latDone = (r_lat == '0);
    assign w_last    = (r_rem <= LEN_W'(1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmdValid) begin
                         if (cmdLen == '0)          w_next = DONE;
                         else if (cmdRW == RW_READ) w_next = RD_REQ;
                         else                       w_next = WR_WAIT;
                     end
            RD_REQ:  w_next = RD_WAIT;
            RD_WAIT: if (w_latDone) w_next = RD_OUT;
            RD_OUT:  if (rdReady) w_next = w_last ? DONE : RD_REQ;
            WR_WAIT: if (wrValid) w_next = WR_REQ;
            WR_REQ:  w_next = w_last ? DONE : WR_WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmdReady = 1'b0;
        rdValid  = 1'b0;
        wrReady  = 1'b0;
        done     = 1'b0;
        memEN    = 1'b0;
        memRW    = RW_READ;
        busy     = (r_state != IDLE);
        case (r_state)
            IDLE:    cmdReady = rstN;  // stay low through reset even though state reads IDLE
            RD_REQ:  memEN    = 1'b1;
            RD_OUT:  rdValid  = 1'b1;
            WR_WAIT: wrReady  = 1'b1;
            WR_REQ:  begin memEN = 1'b1; memRW = RW_WRITE; end
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_addr     <= '0;
            r_rem      <= '0;
            r_lat      <= '0;
            r_rdData   <= '0;
            r_memWrite <= '0;
        end else begin
            if (w_cmdHs) begin
                r_addr <= cmdAddr;
                r_rem  <= cmdLen;
            end else if (w_rdHs || (r_state == WR_REQ)) begin
                r_addr <= r_addr + 1'b1;
                if (r_rem != '0) r_rem <= r_rem - 1'b1;
            end
            // fixed-latency contract: memBus is valid on the final wait cycle
            if (r_state == RD_REQ)                    r_lat <= LAT_W'(MEM_LAT - 1);
            else if (r_state == RD_WAIT && !w_latDone) r_lat <= r_lat - 1'b1;
            if (r_state == RD_WAIT && w_latDone) r_rdData <= memBus;
            if (w_wrHs) r_memWrite <= wrData;
        end
    end

    assign memAddr  = r_addr;
    assign rdData   = r_rdData;
    assign memWrite = r_memWrite;

endmodule
